// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer between a UART receiver and an APB read
// path. A three-state write FSM captures each completed frame through a
// level/acknowledge handshake, and the frame's data byte and parity flag are
// stored in a first-word fall-through FIFO. The block also provides
// occupancy status, a level-threshold interrupt and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_done_i,
    input  logic [31:0]   rx_data_i,
    input  logic          parity_error_i,
    output logic          host_read_data_o,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_perr_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o,
    input  logic [LW-2:0] thresh_i,
    output logic          thresh_irq_o,
    output logic          overrun_o,
    input  logic          clr_overrun_i,
    input  logic          flush_i
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACK,
        W_WAIT_LOW
    } wr_state_e;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } entry_t;

    // Write FSM and handshake state
    wr_state_e     state_q, state_d;
    logic          host_ack_q, host_ack_d;
    logic          overrun_q, overrun_d;

    // FIFO bookkeeping
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    entry_t        mem_q [DEPTH];

    // Per-cycle decisions
    logic          empty;
    logic          full;
    logic          capture;
    logic          pop_valid;
    logic          push_ok;
    logic          push;
    logic          pop;
    entry_t        cap_entry;
    entry_t        head;

    // Only the low byte of the receiver frame is kept.
    logic          unused_rx_bits;
    assign unused_rx_bits = ^rx_data_i[31:8];

    // Status, capture and push/pop qualification.
    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LW'(DEPTH));
        capture   = (state_q == W_IDLE) && rx_done_i;
        pop_valid = rd_en_i && !empty;
        // When full, a push fits only because a pop frees the head slot
        // in the same cycle.
        push_ok   = !full || pop_valid;
        // A flush discards anything that would otherwise move this cycle.
        push      = capture && push_ok && !flush_i;
        pop       = pop_valid && !flush_i;
        cap_entry = '{perr: parity_error_i, data: rx_data_i[7:0]};
    end

    // Next-state logic for the write FSM, FIFO pointers, level and overrun.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overrun_d  = overrun_q;

        // Handshake: capture in IDLE, acknowledge for one cycle, then wait
        // for the receiver to drop rx_done_i before accepting another frame.
        unique case (state_q)
            W_IDLE:     if (rx_done_i) state_d = W_ACK;
            W_ACK:      state_d = W_WAIT_LOW;
            W_WAIT_LOW: if (!rx_done_i) state_d = W_IDLE;
            default:    state_d = W_IDLE;
        endcase

        // The acknowledge is a registered decode of the next state.
        host_ack_d = (state_d == W_ACK);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        // A dropped frame sets the flag even if a clear arrives together
        // with it; a frame lost to a flush is not an overrun.
        if (capture && !push_ok && !flush_i) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= W_IDLE;
            host_ack_q <= 1'b0;
            overrun_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            host_ack_q <= host_ack_d;
            overrun_q  <= overrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; level_q gates every read, so stale
        // contents are never visible and the RAM can map to plain storage.
        if (push) begin
            mem_q[wr_ptr_q] <= cap_entry;
        end
    end

    // First-word fall-through read: the head entry is shown directly,
    // forced to zero while the FIFO holds nothing.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        rd_data_o = empty ? 8'h00 : head.data;
        rd_perr_o = empty ? 1'b0  : head.perr;
    end

    // Interrupt when occupancy reaches a non-zero threshold.
    assign thresh_irq_o     = (thresh_i != '0) && (level_q >= {1'b0, thresh_i});

    assign host_read_data_o = host_ack_q;
    assign overrun_o        = overrun_q;
    assign level_o          = level_q;
    assign empty_o          = empty;
    assign full_o           = full;

endmodule
